// File: rtl/instruction_immediate_encoder.sv
// instruction_immediate_encoder: scatters a 32-bit immediate into RV32I I/S/B/U/J fields of a template,
// two-stage valid/ready pipeline with range/format error flags and a saturating error counter.
module instruction_immediate_encoder #(
  parameter int CHECK_RANGE = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_format_i,
  input  logic             i_format_s,
  input  logic             i_format_b,
  input  logic             i_format_u,
  input  logic             i_format_j,
  input  logic [31:0]      i_template,
  input  logic [31:0]      i_immediate,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_inst,
  output logic             o_range_err,
  output logic             o_format_err,
  input  logic             i_clr_count,
  output logic [CNT_W-1:0] o_err_count
);
  logic        s1_full;
  logic [4:0]  s1_fmt;
  logic [31:0] s1_tmpl;
  logic [31:0] s1_imm;
  logic        stall;
  logic        multi;
  logic        rng;
  logic        range_err;
  logic [31:0] enc;
  logic [31:0] m;
  logic [31:0] t;
  assign stall   = o_valid && !i_ready;
  assign o_ready = !s1_full || !stall;
  // s1_fmt is {j,u,b,s,i}; more than one set bit is a format error
  always_comb begin
    m = s1_imm;
    t = s1_tmpl;
    multi = |(s1_fmt & (s1_fmt - 5'd1));
    enc = multi     ? t :
          s1_fmt[0] ? {m[11:0], t[19:0]} :
          s1_fmt[1] ? {m[11:5], t[24:12], m[4:0], t[6:0]} :
          s1_fmt[2] ? {m[12], m[10:5], t[24:12], m[4:1], m[11], t[6:0]} :
          s1_fmt[3] ? {m[31:12], t[11:0]} :
          s1_fmt[4] ? {m[20], m[10:1], m[11], m[19:12], t[11:0]} : t;
    rng = (s1_fmt[0] | s1_fmt[1]) ? !(&m[31:11] || ~|m[31:11]) :
          s1_fmt[2] ? (m[0] || !(&m[31:12] || ~|m[31:12])) :
          s1_fmt[3] ? (|m[11:0]) :
          s1_fmt[4] ? (m[0] || !(&m[31:20] || ~|m[31:20])) : 1'b0;
    range_err = (CHECK_RANGE != 0) && !multi && rng;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_full      <= 1'b0;
      s1_fmt       <= '0;
      s1_tmpl      <= '0;
      s1_imm       <= '0;
      o_valid      <= 1'b0;
      o_inst       <= '0;
      o_range_err  <= 1'b0;
      o_format_err <= 1'b0;
      o_err_count  <= '0;
    end else begin
      if (o_ready) begin
        s1_full <= i_valid;
        if (i_valid) begin
          s1_fmt  <= {i_format_j, i_format_u, i_format_b, i_format_s, i_format_i};
          s1_tmpl <= i_template;
          s1_imm  <= i_immediate;
        end
      end
      if (!stall) begin
        o_valid <= s1_full;
        if (s1_full) begin
          o_inst       <= enc;
          o_range_err  <= range_err;
          o_format_err <= multi;
        end
      end
      if (i_clr_count)
        o_err_count <= '0;
      else if (o_valid && i_ready && (o_range_err || o_format_err) && !(&o_err_count))
        o_err_count <= o_err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_instruction_immediate_encoder.sv
// tb_instruction_immediate_encoder: directed and random checks against an arithmetic reference model.
module tb_instruction_immediate_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic [4:0]  fmt = '0;
  logic [31:0] tmpl = '0;
  logic [31:0] imm = '0;
  logic        o_ready, o_valid, o_range_err, o_format_err;
  logic [31:0] o_inst;
  logic [7:0]  o_err_count;

  instruction_immediate_encoder #(.CHECK_RANGE(1), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_format_i(fmt[0]), .i_format_s(fmt[1]), .i_format_b(fmt[2]),
    .i_format_u(fmt[3]), .i_format_j(fmt[4]),
    .i_template(tmpl), .i_immediate(imm),
    .o_valid(o_valid), .i_ready(rdy), .o_inst(o_inst),
    .o_range_err(o_range_err), .o_format_err(o_format_err),
    .i_clr_count(clr), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        r;
    logic        f;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_cnt = '0;
  logic        stalled = 1'b0;
  logic [31:0] p_inst = '0;
  logic [1:0]  p_err = '0;
  logic        saw_block;

  // Reference: range rules expressed as signed numeric intervals and alignment
  function automatic exp_t model(logic [4:0] f, logic [31:0] t, logic [31:0] m);
    exp_t e;
    longint v;
    v = longint'($signed(m));
    e.f = $countones(f) > 1;
    e.r = 1'b0;
    e.inst = t;
    if (!e.f) begin
      if (f == 5'b00001) begin
        e.inst = (t & 32'h000F_FFFF) | ((m & 32'hFFF) << 20);
        e.r = v < -2048 || v > 2047;
      end else if (f == 5'b00010) begin
        e.inst = (t & 32'h01FF_F07F) | (((m >> 5) & 32'h7F) << 25) | ((m & 32'h1F) << 7);
        e.r = v < -2048 || v > 2047;
      end else if (f == 5'b00100) begin
        e.inst = (t & 32'h01FF_F07F) | (((m >> 12) & 1) << 31) | (((m >> 5) & 32'h3F) << 25)
               | (((m >> 1) & 32'hF) << 8) | (((m >> 11) & 1) << 7);
        e.r = (m % 2 != 0) || v < -4096 || v > 4095;
      end else if (f == 5'b01000) begin
        e.inst = (t & 32'hFFF) | (m & 32'hFFFF_F000);
        e.r = (m % 4096) != 0;
      end else if (f == 5'b10000) begin
        e.inst = (t & 32'hFFF) | (((m >> 20) & 1) << 31) | (((m >> 1) & 32'h3FF) << 21)
               | (((m >> 11) & 1) << 20) | (m & 32'h000F_F000);
        e.r = (m % 2 != 0) || v < -(64'sd1 << 20) || v >= (64'sd1 << 20);
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic cycle();
    exp_t e;
    logic acc, dlv;
    #1;
    acc = valid && o_ready;
    dlv = o_valid && rdy;
    chk("err_count", {24'd0, o_err_count}, {24'd0, exp_cnt});
    if (stalled) begin
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_inst", o_inst, p_inst);
      chk("hold_err", {30'd0, o_range_err, o_format_err}, {30'd0, p_err});
    end
    e.r = 1'b0;
    e.f = 1'b0;
    if (dlv) begin
      if (q.size() == 0) chk("spurious_valid", {31'd0, o_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("inst", o_inst, e.inst);
        chk("range_err", {31'd0, o_range_err}, {31'd0, e.r});
        chk("format_err", {31'd0, o_format_err}, {31'd0, e.f});
      end
    end
    if (acc) q.push_back(model(fmt, tmpl, imm));
    if (clr) exp_cnt = '0;
    else if (dlv && (e.r || e.f) && exp_cnt != 8'hFF) exp_cnt++;
    stalled = o_valid && !rdy;
    p_inst = o_inst;
    p_err = {o_range_err, o_format_err};
    @(negedge clk);
  endtask

  task automatic directed(input logic [4:0] f, input logic [31:0] t, input logic [31:0] m,
                          input logic [31:0] ei, input logic er, input logic ef);
    fmt = f; tmpl = t; imm = m; valid = 1'b1; rdy = 1'b1;
    cycle();
    valid = 1'b0;
    chk("lat1_valid", {31'd0, o_valid}, 32'd0);
    cycle();
    chk("lat2_valid", {31'd0, o_valid}, 32'd1);
    chk("dir_inst", o_inst, ei);
    chk("dir_range", {31'd0, o_range_err}, {31'd0, er});
    chk("dir_format", {31'd0, o_format_err}, {31'd0, ef});
    cycle();
  endtask

  task automatic drain();
    int k;
    valid = 1'b0; rdy = 1'b1; clr = 1'b0;
    k = 0;
    while ((q.size() != 0 || o_valid) && k < 20) begin
      cycle();
      k++;
    end
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_errs", {30'd0, o_range_err, o_format_err}, 32'd0);
    chk("rst_count", {24'd0, o_err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed(5'b00001, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b0);
    directed(5'b00100, 32'h0000_0063, 32'h0000_0008, 32'h0000_0463, 1'b0, 1'b0);
    directed(5'b10000, 32'h0000_00EF, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0, 1'b0);
    directed(5'b00011, 32'h00A0_0093, 32'h0000_0005, 32'h00A0_0093, 1'b0, 1'b1);
    chk("count_step", {24'd0, o_err_count}, 32'd1);
    directed(5'b00001, 32'h0000_0093, 32'h0000_0800, 32'h8000_0093, 1'b1, 1'b0);
    directed(5'b00100, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1, 1'b0);
    directed(5'b01000, 32'h0000_0037, 32'h1234_5001, 32'h1234_5037, 1'b1, 1'b0);

    fmt = 5'b00011; tmpl = 32'h1234_5678; imm = '0; valid = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    drain();
    chk("count_sat", {24'd0, o_err_count}, 32'd255);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("count_clr", {24'd0, o_err_count}, 32'd0);

    saw_block = 1'b0;
    begin
      int acc_n, c;
      acc_n = 0; c = 0;
      while (acc_n < 4 && c < 20) begin
        fmt = 5'b00001 << (acc_n % 5); tmpl = 32'h0000_0013 + acc_n; imm = 32'h10 * acc_n + 4;
        valid = 1'b1; rdy = (c >= 3);
        #1;
        if (!o_ready) saw_block = 1'b1;
        if (o_ready) acc_n++;
        #1;
        cycle();
        c++;
      end
      chk("b2b_accepted", acc_n, 32'd4);
    end
    chk("ready_drop", {31'd0, saw_block}, 32'd1);
    drain();

    fmt = 5'b00001; tmpl = 32'h0000_0093; imm = 32'h7; valid = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("full_before_rst", {31'd0, o_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    q.delete();
    exp_cnt = '0;
    stalled = 1'b0;
    valid = 1'b0; rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("no_pulse_after_rst", {31'd0, o_valid}, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      int r, mode;
      r = $urandom_range(0, 9);
      fmt = (r < 5) ? (5'b00001 << r) : (r == 5) ? 5'b00000 : 5'($urandom());
      mode = $urandom_range(0, 3);
      imm = (mode == 0) ? $urandom() :
            (mode == 1) ? 32'($urandom_range(0, 8191)) - 32'd4096 :
            (mode == 2) ? ($urandom() & 32'hFFFF_F000) :
                          32'($signed({$urandom_range(0, 1), 20'($urandom())}) );
      tmpl = $urandom();
      valid = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 49) == 0;
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
